// File: rtl/swing_strike_detector.sv
// Multi-channel swing key strike detector: sync, optional debounce, press/release FSM,
// post-strike lockout and ball_zone grading. Debounce filter is built when SWING_DEBOUNCE_EN is defined.
module swing_strike_detector #(
    parameter int CHANNELS = 2,
    parameter int DEBOUNCE = 4,
    parameter int LOCKOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] swing,
    input  logic                ball_zone,
    output logic [CHANNELS-1:0] strike,
    output logic [CHANNELS-1:0] good_hit,
    output logic [CHANNELS-1:0] miss
);

    // state      | meaning
    // WAIT_PRESS | key released, waiting for a debounced press
    // ARMED      | key pressed, waiting for a debounced release
    // FIRE       | strike pulse for one cycle
    // HOLDOFF    | post-strike lockout, key activity ignored
    localparam logic [1:0] S_WAIT_PRESS = 2'd0;
    localparam logic [1:0] S_ARMED      = 2'd1;
    localparam logic [1:0] S_FIRE       = 2'd2;
    localparam logic [1:0] S_HOLDOFF    = 2'd3;

    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = (LOCKOUT > 0) ? LW'(LOCKOUT - 1) : '0;

    if (CHANNELS < 1 || DEBOUNCE < 1 || LOCKOUT < 0) begin : g_param_check
        $error("swing_strike_detector: parameter out of range");
    end

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] deb;

    logic [1:0]    state_q [CHANNELS];
    logic [1:0]    state_d [CHANNELS];
    logic [LW-1:0] lock_q  [CHANNELS];
    logic [LW-1:0] lock_d  [CHANNELS];

    logic                zone_prev_q, zone_prev_d;
    logic [CHANNELS-1:0] hit_flag_q, hit_flag_d;
    logic [CHANNELS-1:0] miss_q, miss_d;
    logic                zone_rise, zone_fall;

    always_comb begin
        sync1_d = swing;
        sync2_d = sync1_q;
    end

`ifdef SWING_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [CHANNELS-1:0] deb_q, deb_d;
    logic [DW-1:0]       dcnt_q [CHANNELS];
    logic [DW-1:0]       dcnt_d [CHANNELS];

    // The counter only advances while the synchronised level disagrees with deb.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            deb_d[c]  = deb_q[c];
            dcnt_d[c] = '0;
            if (sync2_q[c] != deb_q[c]) begin
                if (dcnt_q[c] == DW'(DEBOUNCE - 1)) begin
                    deb_d[c] = sync2_q[c];
                end else begin
                    dcnt_d[c] = dcnt_q[c] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                dcnt_q[c] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int c = 0; c < CHANNELS; c++) begin
                dcnt_q[c] <= dcnt_d[c];
            end
        end
    end

    assign deb = deb_q;
`else
    assign deb = sync2_q;
`endif

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            lock_d[c]  = lock_q[c];
            strike[c]  = (state_q[c] == S_FIRE);
            case (state_q[c])
                S_WAIT_PRESS: if (!deb[c]) state_d[c] = S_ARMED;
                S_ARMED:      if (deb[c])  state_d[c] = S_FIRE;
                S_FIRE: begin
                    if (LOCKOUT > 0) begin
                        state_d[c] = S_HOLDOFF;
                        lock_d[c]  = LOCK_LOAD;
                    end else begin
                        state_d[c] = S_WAIT_PRESS;
                    end
                end
                S_HOLDOFF: begin
                    if (lock_q[c] == '0) begin
                        state_d[c] = S_WAIT_PRESS;
                    end else begin
                        lock_d[c] = lock_q[c] - LW'(1);
                    end
                end
                default: state_d[c] = S_WAIT_PRESS;
            endcase
        end
    end

    assign good_hit = strike & {CHANNELS{ball_zone}};

    // A good hit in the first zone cycle must survive the rising-edge clear.
    always_comb begin
        zone_rise   = ball_zone & ~zone_prev_q;
        zone_fall   = ~ball_zone & zone_prev_q;
        zone_prev_d = ball_zone;
        hit_flag_d  = (zone_rise ? '0 : hit_flag_q) | good_hit;
        miss_d      = zone_fall ? ~hit_flag_q : '0;
    end

    assign miss = miss_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            zone_prev_q <= 1'b0;
            hit_flag_q  <= '0;
            miss_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= S_WAIT_PRESS;
                lock_q[c]  <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            zone_prev_q <= zone_prev_d;
            hit_flag_q  <= hit_flag_d;
            miss_q      <= miss_d;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                lock_q[c]  <= lock_d[c];
            end
        end
    end

endmodule

// File: tb/tb_swing_strike_detector.sv
// Scoreboard bench for swing_strike_detector: a default instance and a LOCKOUT=0 instance
// share stimulus; expected output cycles are queued and a negedge monitor compares them.
module tb_swing_strike_detector;

    localparam int DEB = 4;
`ifdef SWING_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 2;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] swing;
    logic       ball_zone;
    logic [1:0] a_strike, a_good_hit, a_miss;
    logic [1:0] b_strike, b_good_hit, b_miss;

    typedef struct {
        int         cyc;
        logic [11:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [11:0] obs;

    swing_strike_detector #(.CHANNELS(2), .DEBOUNCE(DEB), .LOCKOUT(16)) dut_a (
        .clock(clock), .reset(reset), .swing(swing), .ball_zone(ball_zone),
        .strike(a_strike), .good_hit(a_good_hit), .miss(a_miss)
    );

    swing_strike_detector #(.CHANNELS(2), .DEBOUNCE(DEB), .LOCKOUT(0)) dut_b (
        .clock(clock), .reset(reset), .swing(swing), .ball_zone(ball_zone),
        .strike(b_strike), .good_hit(b_good_hit), .miss(b_miss)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign obs = {a_strike, a_good_hit, a_miss, b_strike, b_good_hit, b_miss};

    // mask[1] selects the LOCKOUT=16 instance, mask[0] the LOCKOUT=0 instance
    function automatic void push(int c, logic [1:0] mask, logic [1:0] s, logic [1:0] g, logic [1:0] m);
        logic [11:0] v;
        v = {(mask[1] ? {s, g, m} : 6'b0), (mask[0] ? {s, g, m} : 6'b0)};
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc == c) begin
                q[i].val = q[i].val | v;
                return;
            end
            if (q[i].cyc > c) begin
                q.insert(i, '{c, v});
                return;
            end
        end
        q.push_back('{c, v});
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            logic [11:0] exp_v;
            logic        had_exp;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_output cyc=%0d expected=%03h never compared", q[0].cyc, q[0].val);
                void'(q.pop_front());
            end
            had_exp = 1'b0;
            exp_v   = '0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                had_exp = 1'b1;
                exp_v   = q[0].val;
                void'(q.pop_front());
            end
            if (had_exp || obs != 12'h000) begin
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got=%03h expected=%03h", cyc, obs, exp_v);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL %s got=%03h expected=000", name, obs);
        end
    endtask

    task automatic swing_ch(input logic [1:0] m, input int hold, input logic [1:0] gh);
        swing = swing & ~m;
        step(hold);
        swing = swing | m;
        push(cyc + 1 + LAT, 2'b11, m, gh, 2'b00);
    endtask

    initial begin
        int s_cyc;
        int base;
        int r0;
        int r1;
        logic [8:0] pat;

        reset     = 1'b1;
        swing     = 2'b11;
        ball_zone = 1'b0;
        step(3);
        check_zero("reset_out");
        reset  = 1'b0;
        mon_en = 1'b1;
        step(5);

        // clean swing on channel 0
        swing_ch(2'b01, 10, 2'b00);
        step(40);

`ifdef SWING_DEBOUNCE_EN
        // bouncing release: high pulses of 1, 2 and 3 samples separated by low samples
        swing[0] = 1'b0;
        step(10);
        pat = 9'b101101110;
        for (int i = 8; i >= 0; i--) begin
            swing[0] = pat[i];
            step(1);
        end
        swing[0] = 1'b1;
        push(cyc + 1 + LAT, 2'b11, 2'b01, 2'b00, 2'b00);
        step(40);
`else
        // without the filter a single low sample is a full swing
        pat = 9'b0;
        swing[0] = pat[0];
        step(1);
        swing[0] = 1'b1;
        push(cyc + 1 + LAT, 2'b11, 2'b01, 2'b00, 2'b00);
        step(40);
`endif

        // lockout: second swing striking 10 cycles later only fires with LOCKOUT=0
        swing_ch(2'b01, 10, 2'b00);
        s_cyc = cyc + 1 + LAT;
        while (cyc < s_cyc - 1) step(1);
        swing[0] = 1'b0;
        step(4);
        swing[0] = 1'b1;
        push(cyc + 1 + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
        while (cyc < s_cyc + 20) step(1);
        swing_ch(2'b01, 10, 2'b00);
        step(40);

        // zone grading: ch0 strikes inside the window, ch1 two cycles after close
        base = cyc;
        r0   = 29 - LAT;
        r1   = 41 - LAT;
        push(base + 30, 2'b11, 2'b01, 2'b01, 2'b00);
        push(base + 41, 2'b11, 2'b00, 2'b00, 2'b10);
        push(base + 42, 2'b11, 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < 60; k++) begin
            swing[0]  = !(k >= 5 && k < r0);
            swing[1]  = !(k >= 10 && k < r1);
            ball_zone = (k >= 20 && k < 40);
            step(1);
        end
        step(20);

        // simultaneous release on both channels
        swing_ch(2'b11, 10, 2'b00);
        step(40);

        // reset during release debounce with the key pressed again
        swing[0] = 1'b0;
        step(10);
        swing[0] = 1'b1;
        step(2);
        reset    = 1'b1;
        swing[0] = 1'b0;
        step(2);
        check_zero("rst_mid_out");
        reset = 1'b0;
        step(10);
        swing[0] = 1'b1;
        push(cyc + 1 + LAT, 2'b11, 2'b01, 2'b00, 2'b00);
        step(40);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
